instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 114 +++++++++++
 tb/tb_instr_fetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, issues one word read at a time to imem and
// presents the fetched word to decode through a one-entry valid/ready output register.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_kill, w_kill_nxt;
  logic        r_vld, w_vld_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_ipc, w_ipc_nxt;
  logic [31:0] w_redir_pc;

  assign w_redir_pc = {redirect_pc[31:2], 2'b00};

  // A redirect suppresses the request in the same cycle so no stale fetch is accepted.
  assign imem_req_valid = reset_n && (r_state == S_REQ) && !redirect_valid;
  assign imem_req_addr  = r_pc;

  assign instr_valid = r_vld;
  assign instr       = r_instr;
  assign instr_pc    = r_ipc;
  assign op          = r_instr[6:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_REQ;
      r_pc    <= RST_PC;
      r_kill  <= 1'b0;
      r_vld   <= 1'b0;
      r_instr <= NOP;
      r_ipc   <= RST_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
      r_vld   <= w_vld_nxt;
      r_instr <= w_instr_nxt;
      r_ipc   <= w_ipc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_vld_nxt   = r_vld;
    w_instr_nxt = r_instr;
    w_ipc_nxt   = r_ipc;
    case (r_state)
      S_REQ: begin
        if (redirect_valid)      w_pc_nxt    = w_redir_pc;
        else if (imem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
          // A response landing with the redirect is the stale word itself: drop it now
          // rather than arming kill for a response that will never come.
          if (imem_rsp_valid) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_kill_nxt  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (r_kill) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_instr_nxt = imem_rsp_data;
            w_ipc_nxt   = r_pc;
            w_vld_nxt   = 1'b1;
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_vld_nxt   = 1'b0;
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_REQ;
        end else if (instr_ready) begin
          w_vld_nxt   = 1'b0;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level model of the fetch stream (expected PC,
// live/killed outstanding request, output slot) driven by directed and random stimulus.
module tb_instr_fetch;

  logic        clk, reset_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        instr_valid, instr_ready, redirect_valid;
  logic [31:0] instr, instr_pc, redirect_pc;
  logic [6:0]  op;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .op(op), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // reference model: expected next fetch PC, outstanding request, output slot
  logic [31:0] m_pc;
  logic        pend, live, m_sv;
  logic [31:0] pend_addr, m_si, m_sp;
  int          wcnt, lat;
  int          cyc, n_hs, n_acc, fv_cyc, last_hs;
  int          hs_cyc[$];
  logic [31:0] last_addr, prev_addr;

  task automatic model_reset();
    m_pc = 32'h0; pend = 0; live = 0; m_sv = 0; wcnt = 0;
  endtask

  // one clock cycle, entered and left at the falling edge
  task automatic step(input logic rdy, input logic rd, input logic [31:0] tgt, input logic irdy);
    logic hs;
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_sv});
    if (m_sv) begin
      chk("instr", instr, m_si);
      chk("instr_pc", instr_pc, m_sp);
      chk("op", {25'b0, op}, {25'b0, m_si[6:0]});
    end
    if (instr_valid && fv_cyc < 0) fv_cyc = cyc;
    imem_req_ready = rdy; redirect_valid = rd; redirect_pc = tgt; instr_ready = irdy;
    imem_rsp_valid = pend && (wcnt == 0);
    imem_rsp_data  = pend_addr ^ 32'hA5A5_0000;
    #1;
    if (rd) chk("noreq_on_redirect", {31'b0, imem_req_valid}, 32'h0);
    if (pend || m_sv) chk("single_outstanding", {31'b0, imem_req_valid}, 32'h0);
    hs = imem_req_valid && rdy;
    if (hs) begin
      chk("req_addr", imem_req_addr, m_pc);
      prev_addr = last_addr; last_addr = imem_req_addr;
      last_hs = cyc; hs_cyc.push_back(cyc); n_hs++;
    end
    if (instr_valid && irdy) begin m_sv = 0; n_acc++; end
    if (imem_rsp_valid) begin
      if (live && !rd) begin
        m_sv = 1; m_si = imem_rsp_data; m_sp = pend_addr; m_pc = pend_addr + 32'd4;
      end
      pend = 0; live = 0;
    end else if (pend) wcnt--;
    if (hs) begin pend = 1; pend_addr = imem_req_addr; wcnt = lat; live = 1; end
    if (rd) begin m_pc = {tgt[31:2], 2'b00}; live = 0; m_sv = 0; end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int c, hs0;
    logic [31:0] sp;
    reset_n = 1; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    instr_ready = 0; redirect_valid = 0; redirect_pc = 0;
    cyc = 0; n_hs = 0; n_acc = 0; fv_cyc = -1; last_hs = -1; lat = 0;
    last_addr = 0; prev_addr = 0;
    model_reset();
    #1 reset_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_op", {25'b0, op}, 32'h13);
    chk("rst_instr_pc", instr_pc, 32'h0);
    reset_n = 1;
    #1 chk("req_after_rst", {31'b0, imem_req_valid}, 32'h1);

    // zero-wait memory, downstream always ready: 3-cycle cadence, 2-cycle latency
    hs_cyc.delete(); fv_cyc = -1;
    repeat (12) step(1, 0, 0, 1);
    chk("hs_count", hs_cyc.size(), 4);
    if (hs_cyc.size() >= 3) begin
      chk("cadence0", hs_cyc[1] - hs_cyc[0], 3);
      chk("cadence1", hs_cyc[2] - hs_cyc[1], 3);
      chk("first_latency", fv_cyc - hs_cyc[0], 2);
    end

    // backpressure in HOLD
    for (int i = 0; i < 10 && !m_sv; i++) step(1, 0, 0, 0);
    chk("reach_hold", {31'b0, m_sv}, 32'h1);
    sp = m_sp; hs0 = n_hs;
    repeat (5) step(1, 0, 0, 0);
    chk("bp_no_req", n_hs, hs0);
    step(1, 0, 0, 1);
    c = cyc;
    step(1, 0, 0, 1);
    chk("bp_req_next", last_hs, c);
    chk("bp_req_addr", last_addr, sp + 32'd4);

    // redirect in WAIT, response 3 cycles later is dropped
    lat = 3;
    for (int i = 0; i < 10 && !pend; i++) step(1, 0, 0, 1);
    chk("reach_wait", {31'b0, pend}, 32'h1);
    lat = 0;
    step(1, 1, 32'h0000_0103, 1);
    hs0 = n_hs;
    for (int i = 0; i < 12 && n_hs == hs0; i++) step(1, 0, 0, 1);
    chk("kill_refetch", last_addr, 32'h0000_0100);

    // redirect with same-cycle response, then redirect while in REQ
    for (int i = 0; i < 10 && !pend; i++) step(1, 0, 0, 1);
    step(1, 1, 32'h0000_0200, 1);
    redirect_valid = 0;
    #1;
    chk("rsp_redir_req", {31'b0, imem_req_valid}, 32'h1);
    chk("rsp_redir_addr", imem_req_addr, 32'h0000_0200);
    hs0 = n_hs;
    step(1, 1, 32'h0000_0300, 1);
    chk("req_redir_nohs", n_hs, hs0);
    step(1, 0, 0, 1);
    chk("req_redir_addr", last_addr, 32'h0000_0300);

    // redirect in HOLD with concurrent instr_ready
    for (int i = 0; i < 10 && !m_sv; i++) step(1, 0, 0, 0);
    step(1, 1, 32'h0000_0400, 1);
    chk("hold_redir_vld", {31'b0, instr_valid}, 32'h0);
    step(1, 0, 0, 1);
    chk("hold_redir_addr", last_addr, 32'h0000_0400);

    // PC wrap (low bits of target ignored)
    step(1, 1, 32'hFFFF_FFFE, 1);
    hs0 = n_hs;
    for (int i = 0; i < 12 && n_hs < hs0 + 2; i++) step(1, 0, 0, 1);
    chk("wrap_first", prev_addr, 32'hFFFF_FFFC);
    chk("wrap_next", last_addr, 32'h0000_0000);

    // reset pulse while a fetch is in flight
    step(1, 1, 32'h0000_0800, 1);
    lat = 3;
    for (int i = 0; i < 10 && !pend; i++) step(1, 0, 0, 1);
    lat = 0;
    #2 reset_n = 0;
    #1;
    chk("midrst_vld", {31'b0, instr_valid}, 32'h0);
    chk("midrst_instr", instr, 32'h0000_0013);
    chk("midrst_req", {31'b0, imem_req_valid}, 32'h0);
    imem_rsp_valid = 0;
    model_reset();
    @(negedge clk);
    reset_n = 1;
    hs0 = n_hs;
    for (int i = 0; i < 5 && n_hs == hs0; i++) step(1, 0, 0, 1);
    chk("midrst_refetch", last_addr, 32'h0);

    // random traffic
    hs0 = n_acc;
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(0, 3);
      step(($urandom % 4) != 0, ($urandom % 12) == 0, $urandom, ($urandom % 3) != 0);
    end
    chk("progress", {31'b0, (n_acc - hs0) > 200}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
